free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register numbers for the 3-way rename/dispatch stage.
- Sits directly upstream of dispatch: supplies up to 3 new PRs per cycle for destination renaming (the free_pr / free_pr_valid / new_pr_en contract).
- Reclaims Told PRs from ROB retirement.
- Restores the architectural free state on a squash.

Parameters:
- PR, 6, physical register index width (2**PR physical registers).
- AR_NUM, 32, architectural registers, permanently mapped at reset.
- FL_SIZE, 2**PR-AR_NUM (32), free-list capacity.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- new_pr_en  in  3  dispatch way i consumes a free PR this cycle.
- free_pr_valid  out  3  ways able to receive a PR; thermometer from way 2 (oldest).
- free_pr  out  3xPR  PR offered to each way, compacted by new_pr_en.
- retire_en  in  3  ROB way i retires and frees retire_pr[i].
- retire_pr  in  3xPR  Told of retiring way i.
- squash  in  1  mispredict/exception recovery at ROB head.
- fl_array_display  out  FL_SIZExPR  debug: storage array.
- fl_head_display  out  log2(FL_SIZE)  debug: head pointer.
- fl_tail_display  out  log2(FL_SIZE)  debug: tail pointer.
- fl_empty_display  out  1  debug: count==0.

Behaviour:
- Ordering: way 2 is oldest. Pops and pushes are processed in way order 2,1,0.
- State: array[FL_SIZE], head, tail, count (width log2(FL_SIZE)+1). Pointers wrap modulo FL_SIZE (power of two, natural wrap).
- Reset (async, reset_n=0): array[i]=AR_NUM+i, head=0, tail=0, count=FL_SIZE. This gives free_pr={32,33,34} and free_pr_valid=111 while en=000.
- free_pr_valid (combinational from count):
  - count>=3 -> 111
  - count==2 -> 110
  - count==1 -> 100
  - count==0 -> 000
- free_pr[i] = array[head + popcount(new_pr_en[2:i+1])], combinational from new_pr_en in the same cycle. Zero latency.
- Pop: at posedge, head += popcount(new_pr_en) and count -= popcount(new_pr_en).
  - new_pr_en must be a subset of the ways whose free_pr_valid bit is set.
  - Violation is a simulation assertion; RTL clamps the pop to count.
- Push: at posedge, array[tail + popcount(retire_en[2:i+1])] = retire_pr[i] for each enabled way. Then tail += popcount(retire_en) and count += popcount(retire_en).
  - count>FL_SIZE is an assertion (double free).
- Same-cycle pop and push: both apply, and count moves by the net amount. PRs freed this cycle are not visible on free_pr until the next cycle; no bypass.
- Empty: count==0 gives free_pr_valid=000 and fl_empty_display=1. free_pr values are don't-care.
- Full: count==FL_SIZE with head==tail is legal (the reset state).
- Squash:
  - Same-cycle retire pushes are applied first.
  - Then head <= new tail and count <= FL_SIZE.
  - new_pr_en is ignored that cycle.
  - Speculatively popped entries are still present in the array, so the list is restored intact.
- Debug outputs are direct register views and reset with the state.

Decomposition:
- Shared package: constants `PR, `FL_SIZE, AR_NUM.
- Sub-module free_list_offset: combinational 3-bit prefix popcount returning per-way offsets (0..2) and total (0..3). Instantiated twice, for pop and push.

Test Plan:
- Reset: hold reset_n=0 then release, en=000 -> free_pr={32,33,34}, valid=111, head=0, tail=0, count=32, empty=0.
- Pop 111 at the first edge -> next cycle free_pr={35,36,37}, head=3.
- Then en=101 -> free_pr[2]=35, free_pr[0]=36; after the edge head=5.
- Drain: 10 cycles of en=111 then en=110 -> count=0, valid=000, empty=1.
- From the drained state, retire_en=100, pr=7 -> next cycle valid=100, free_pr[2]=7, tail advanced by 1.
- Same cycle: en=111 popping {32,33,34} and retire_en=111 pushing {1,2,3} -> count unchanged at 32. array[tail-3..tail-1]={1,2,3}. free_pr next cycle ={35,36,37}, so pushed PRs are not bypassed.
- Squash after 9 pops with retire_en=010, pr=5 in the same cycle -> count=32, head=tail=1, array[0]=5, free_pr next cycle ={33,34,35}.
- Mid-operation reset: assert reset_n=0 asynchronously between edges while count=10 -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizing constants for the rename-stage free list.
package free_list_pkg;

    localparam int unsigned PR      = 6;
    localparam int unsigned AR_NUM  = 32;
    localparam int unsigned FL_SIZE = (1 << PR) - AR_NUM;
    localparam int unsigned FL_W    = $clog2(FL_SIZE);
    localparam int unsigned CNT_W   = FL_W + 1;
    localparam int unsigned WAYS    = 3;

endpackage

// File: rtl/free_list_offset.sv
// Prefix popcount over a 3-way enable vector, way 2 oldest.
// offset[2i+:2] counts enabled ways strictly older than way i; total counts all.
module free_list_offset (
    input  logic [2:0] en,
    output logic [5:0] offset,
    output logic [1:0] total
);

    // Per-way offsets and total from the older ways' enables
    always_comb begin
        offset      = 6'd0;
        offset[5:4] = 2'd0;
        offset[3:2] = 2'(en[2]);
        offset[1:0] = 2'(en[2]) + 2'(en[1]);
        total       = 2'(en[2]) + 2'(en[1]) + 2'(en[0]);
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register numbers for 3-wide rename.
// Pops feed dispatch with zero latency, pushes reclaim retired Told PRs,
// and squash rewinds head onto tail to restore the architectural free state.
module free_list
    import free_list_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [2:0]              new_pr_en,
    output logic [2:0]              free_pr_valid,
    output logic [3*PR-1:0]         free_pr,
    input  logic [2:0]              retire_en,
    input  logic [3*PR-1:0]         retire_pr,
    input  logic                    squash,
    output logic [FL_SIZE*PR-1:0]   fl_array_display,
    output logic [FL_W-1:0]         fl_head_display,
    output logic [FL_W-1:0]         fl_tail_display,
    output logic                    fl_empty_display
);

    logic [PR-1:0]    fl_array [FL_SIZE];
    logic [FL_W-1:0]  head;
    logic [FL_W-1:0]  tail;
    logic [CNT_W-1:0] count;

    logic [5:0]       pop_off;
    logic [5:0]       push_off;
    logic [1:0]       pop_total;
    logic [1:0]       push_total;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] count_next;
    logic [FL_W-1:0]  tail_next;

    free_list_offset u_pop_offset (
        .en     (new_pr_en),
        .offset (pop_off),
        .total  (pop_total)
    );

    free_list_offset u_push_offset (
        .en     (retire_en),
        .offset (push_off),
        .total  (push_total)
    );

    // Pop is clamped to what is actually available; push/pop net into count
    always_comb begin
        pop_cnt    = (CNT_W'(pop_total) > count) ? count : CNT_W'(pop_total);
        tail_next  = tail + FL_W'(push_total);
        count_next = count - pop_cnt + CNT_W'(push_total);
    end

    // Availability thermometer from the oldest way down
    always_comb begin
        free_pr_valid = 3'b000;
        if (count >= CNT_W'(3))
            free_pr_valid = 3'b111;
        else if (count == CNT_W'(2))
            free_pr_valid = 3'b110;
        else if (count == CNT_W'(1))
            free_pr_valid = 3'b100;
    end

    // Each way sees the entry skipped past by older consuming ways
    always_comb begin
        free_pr = '0;
        for (int i = 0; i < 3; i++)
            free_pr[i*PR +: PR] = fl_array[head + FL_W'(pop_off[2*i +: 2])];
    end

    // Debug views of the raw state
    always_comb begin
        fl_array_display = '0;
        for (int i = 0; i < int'(FL_SIZE); i++)
            fl_array_display[i*PR +: PR] = fl_array[FL_W'(i)];
        fl_head_display  = head;
        fl_tail_display  = tail;
        fl_empty_display = (count == '0);
    end

    // Storage, pointers and occupancy; retire pushes land before a squash rewind
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FL_SIZE); i++)
                fl_array[FL_W'(i)] <= PR'(AR_NUM + i);
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FL_SIZE);
        end else begin
            for (int i = 0; i < 3; i++)
                if (retire_en[i])
                    fl_array[tail + FL_W'(push_off[2*i +: 2])] <= retire_pr[i*PR +: PR];
            tail <= tail_next;
            if (squash) begin
                head  <= tail_next;
                count <= CNT_W'(FL_SIZE);
            end else begin
                head  <= head + FL_W'(pop_cnt);
                count <= count_next;
            end
        end
    end

`ifndef SYNTHESIS
    // Dispatch may only consume ways that were offered a PR
    pop_within_valid: assert property (@(posedge clock) disable iff (!reset_n)
        !squash |-> ((new_pr_en & ~free_pr_valid) == 3'b000));

    // Reclaiming more PRs than were handed out means a double free
    no_double_free: assert property (@(posedge clock) disable iff (!reset_n)
        !squash |-> (count_next <= CNT_W'(FL_SIZE)));
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomised bench for free_list against a queue-level model of free and
// handed-out PRs, plus literal expectations pinning the model.
module tb_free_list;
    import free_list_pkg::*;

    logic                  clock;
    logic                  reset_n;
    logic [2:0]            new_pr_en;
    logic [2:0]            free_pr_valid;
    logic [3*PR-1:0]       free_pr;
    logic [2:0]            retire_en;
    logic [3*PR-1:0]       retire_pr;
    logic                  squash;
    logic [FL_SIZE*PR-1:0] fl_array_display;
    logic [FL_W-1:0]       fl_head_display;
    logic [FL_W-1:0]       fl_tail_display;
    logic                  fl_empty_display;

    free_list dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .new_pr_en        (new_pr_en),
        .free_pr_valid    (free_pr_valid),
        .free_pr          (free_pr),
        .retire_en        (retire_en),
        .retire_pr        (retire_pr),
        .squash           (squash),
        .fl_array_display (fl_array_display),
        .fl_head_display  (fl_head_display),
        .fl_tail_display  (fl_tail_display),
        .fl_empty_display (fl_empty_display)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: free PRs in hand-out order, and handed-out PRs in pop order
    int free_q[$];
    int popped[$];
    int hd;
    int tl;
    int total;
    int bad;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fp(input int w);
        return int'(free_pr[w*PR +: PR]);
    endfunction

    function automatic int slot(input int s);
        return int'(fl_array_display[(s % int'(FL_SIZE))*PR +: PR]);
    endfunction

    function automatic int older_en(input logic [2:0] en, input int w);
        int n = 0;
        for (int k = w + 1; k < 3; k++)
            n += int'(en[k]);
        return n;
    endfunction

    function automatic logic [2:0] exp_valid(input int n);
        if (n >= 3) return 3'b111;
        if (n == 2) return 3'b110;
        if (n == 1) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_reset();
        free_q.delete();
        popped.delete();
        for (int k = 0; k < int'(FL_SIZE); k++)
            free_q.push_back(int'(AR_NUM) + k);
        hd = 0;
        tl = 0;
    endtask

    // Compare all observable outputs with the model for the current inputs
    task automatic compare_all();
        logic [2:0] v;
        v = exp_valid(free_q.size());
        chk("valid", int'(free_pr_valid), int'(v));
        chk("empty", int'(fl_empty_display), int'(free_q.size() == 0));
        chk("head", int'(fl_head_display), hd);
        chk("tail", int'(fl_tail_display), tl);
        for (int w = 0; w < 3; w++)
            if (v[w])
                chk($sformatf("free_pr%0d", w), fp(w), free_q[older_en(new_pr_en, w)]);
        for (int k = 0; k < free_q.size(); k++)
            chk("free_slot", slot(hd + k), free_q[k]);
        for (int k = 0; k < popped.size(); k++)
            chk("used_slot", slot(tl + k), popped[k]);
    endtask

    // Advance the model across the edge using the inputs being driven
    task automatic model_edge();
        if (!squash) begin
            for (int w = 2; w >= 0; w--)
                if (new_pr_en[w] && free_q.size() > 0)
                    popped.push_back(free_q.pop_front());
            hd = (hd + $countones(new_pr_en)) % int'(FL_SIZE);
        end
        for (int w = 2; w >= 0; w--)
            if (retire_en[w]) begin
                if (popped.size() > 0) void'(popped.pop_front());
                free_q.push_back(int'(retire_pr[w*PR +: PR]));
            end
        tl = (tl + $countones(retire_en)) % int'(FL_SIZE);
        if (squash) begin
            while (popped.size() > 0)
                free_q.push_front(popped.pop_back());
            hd = tl;
        end
    endtask

    task automatic drive(input logic [2:0] en, input logic [2:0] ren,
                         input logic [3*PR-1:0] rpr, input logic sq);
        @(negedge clock);
        new_pr_en = en;
        retire_en = ren;
        retire_pr = rpr;
        squash    = sq;
        #1;
        compare_all();
    endtask

    task automatic clk_edge();
        @(posedge clock);
        model_edge();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        new_pr_en = 3'b000;
        retire_en = 3'b000;
        retire_pr = '0;
        squash    = 1'b0;
        repeat (2) @(posedge clock);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [3*PR-1:0] prs(input int p2, input int p1, input int p0);
        return {PR'(p2), PR'(p1), PR'(p0)};
    endfunction

    initial begin
        logic [2:0] en;
        logic [2:0] ren;
        logic       sq;
        int         allowed;

        total = 0;
        bad   = 0;

        // Reset values and the first pops
        do_reset();
        drive(3'b000, 3'b000, '0, 1'b0);
        chk("rst_valid", int'(free_pr_valid), 7);
        chk("rst_head", int'(fl_head_display), 0);
        chk("rst_tail", int'(fl_tail_display), 0);
        chk("rst_empty", int'(fl_empty_display), 0);
        chk("rst_fp2", fp(2), 32);
        drive(3'b111, 3'b000, '0, 1'b0);
        chk("p0_fp2", fp(2), 32);
        chk("p0_fp1", fp(1), 33);
        chk("p0_fp0", fp(0), 34);
        clk_edge();
        drive(3'b101, 3'b000, '0, 1'b0);
        chk("p1_fp2", fp(2), 35);
        chk("p1_fp0", fp(0), 36);
        chk("p1_head", int'(fl_head_display), 3);
        clk_edge();
        drive(3'b000, 3'b000, '0, 1'b0);
        chk("p2_head", int'(fl_head_display), 5);

        // Drain to empty, then reclaim one PR
        do_reset();
        repeat (10) begin
            drive(3'b111, 3'b000, '0, 1'b0);
            clk_edge();
        end
        drive(3'b110, 3'b000, '0, 1'b0);
        clk_edge();
        drive(3'b000, 3'b100, prs(7, 0, 0), 1'b0);
        chk("drain_valid", int'(free_pr_valid), 0);
        chk("drain_empty", int'(fl_empty_display), 1);
        clk_edge();
        drive(3'b000, 3'b000, '0, 1'b0);
        chk("refill_valid", int'(free_pr_valid), 4);
        chk("refill_fp2", fp(2), 7);
        chk("refill_tail", int'(fl_tail_display), 1);

        // Simultaneous pop and push, no bypass of pushed PRs
        do_reset();
        drive(3'b111, 3'b111, prs(1, 2, 3), 1'b0);
        clk_edge();
        drive(3'b111, 3'b000, '0, 1'b0);
        chk("pp_fp2", fp(2), 35);
        chk("pp_fp1", fp(1), 36);
        chk("pp_fp0", fp(0), 37);
        chk("pp_arr0", slot(0), 1);
        chk("pp_arr1", slot(1), 2);
        chk("pp_arr2", slot(2), 3);
        chk("pp_valid", int'(free_pr_valid), 7);

        // Squash after nine pops with a same-cycle retire
        do_reset();
        repeat (3) begin
            drive(3'b111, 3'b000, '0, 1'b0);
            clk_edge();
        end
        drive(3'b111, 3'b010, prs(0, 5, 0), 1'b1);
        clk_edge();
        drive(3'b111, 3'b000, '0, 1'b0);
        chk("sq_fp2", fp(2), 33);
        chk("sq_fp1", fp(1), 34);
        chk("sq_fp0", fp(0), 35);
        chk("sq_head", int'(fl_head_display), 1);
        chk("sq_tail", int'(fl_tail_display), 1);
        chk("sq_arr0", slot(0), 5);

        // Asynchronous reset between edges with ten PRs left
        do_reset();
        repeat (7) begin
            drive(3'b111, 3'b000, '0, 1'b0);
            clk_edge();
        end
        drive(3'b100, 3'b000, '0, 1'b0);
        clk_edge();
        drive(3'b000, 3'b000, '0, 1'b0);
        chk("pre_arst_head", int'(fl_head_display), 22);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_head", int'(fl_head_display), 0);
        chk("arst_fp2", fp(2), 32);
        chk("arst_valid", int'(free_pr_valid), 7);
        model_reset();
        compare_all();

        // Randomised traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            en  = 3'($urandom) & exp_valid(free_q.size());
            if (c % 400 < 200 && ($urandom_range(0, 3) == 0)) en = 3'b000;
            sq  = ($urandom_range(0, 49) == 0);
            ren = 3'($urandom);
            if (c % 400 >= 200 && ($urandom_range(0, 1) == 0)) ren = 3'b000;
            allowed = int'(FL_SIZE) - free_q.size() + (sq ? 0 : $countones(en));
            while ($countones(ren) > allowed)
                ren = ren & (ren - 3'd1);
            drive(en, ren, (3*PR)'({$urandom, $urandom}), sq);
            clk_edge();
        end
        drive(3'b000, 3'b000, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
